// File: rtl/comparator_iter_if.sv
// Request/result handshake bundle for comparator_iter.
// The master side supplies operands and consumes results; the slave side is the comparator.
interface comparator_iter_if #(
   parameter int unsigned N = 32
);
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [1:0]   mode;
   logic         i_valid;
   logic         o_ready;
   logic         o_valid;
   logic         i_ready;
   logic         out;

   modport master (
      output a, b, mode, i_valid, i_ready,
      input  o_ready, o_valid, out
   );

   modport slave (
      input  a, b, mode, i_valid, i_ready,
      output o_ready, o_valid, out
   );
endinterface

// File: rtl/comparator_iter.sv
// Iterative EQ/NE/LT/LTU comparator: CHUNK bits per cycle, MSB chunk first.
// Define COMPARATOR_ITER_EARLY_EXIT_EN to finish on the first differing chunk.
module comparator_iter #(
   parameter int unsigned N     = 32,
   parameter int unsigned CHUNK = 8
) (
   input logic              clk,
   input logic              rst,
   comparator_iter_if.slave bus
);
   localparam int unsigned  K       = N / CHUNK;
   localparam int unsigned  IdxW    = (K > 1) ? $clog2(K) : 1;
   localparam logic [N-1:0] MsbMask = N'(1) << (N - 1);
   localparam logic [1:0]   ModeEq  = 2'b00;
   localparam logic [1:0]   ModeNe  = 2'b01;
   localparam logic [1:0]   ModeLt  = 2'b10;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      a_q, a_d;
   logic [N-1:0]      b_q, b_d;
   logic [1:0]        mode_q, mode_d;
   logic              decided_q, decided_d;
   logic              lt_q, lt_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              out_q, out_d;

   logic [CHUNK-1:0]  ca, cb;
   logic              first_diff;
   logic              last;
   logic              early;
   logic [N-1:0]      flip;

   assign ca         = CHUNK'(a_q >> (CHUNK * idx_q));
   assign cb         = CHUNK'(b_q >> (CHUNK * idx_q));
   assign first_diff = !decided_q && (ca != cb);
   assign last       = (idx_q == '0);
   // Signed compare becomes unsigned once both sign bits are flipped.
   assign flip       = (bus.mode == ModeLt) ? MsbMask : '0;

`ifdef COMPARATOR_ITER_EARLY_EXIT_EN
   assign early = first_diff;
`else
   assign early = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      mode_d    = mode_q;
      decided_d = decided_q;
      lt_d      = lt_q;
      idx_d     = idx_q;
      out_d     = out_q;
      unique case (state_q)
         StIdle: begin
            if (bus.i_valid) begin
               a_d       = bus.a ^ flip;
               b_d       = bus.b ^ flip;
               mode_d    = bus.mode;
               decided_d = 1'b0;
               lt_d      = 1'b0;
               idx_d     = IdxW'(K - 1);
               state_d   = StRun;
            end
         end
         StRun: begin
            if (first_diff) begin
               decided_d = 1'b1;
               lt_d      = (ca < cb);
            end
            if (last || early) begin
               state_d = StDone;
               case (mode_q)
                  ModeEq:  out_d = ~decided_d;
                  ModeNe:  out_d = decided_d;
                  default: out_d = lt_d;
               endcase
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         StDone: begin
            if (bus.i_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= '0;
         decided_q <= 1'b0;
         lt_q      <= 1'b0;
         idx_q     <= '0;
         out_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         mode_q    <= mode_d;
         decided_q <= decided_d;
         lt_q      <= lt_d;
         idx_q     <= idx_d;
         out_q     <= out_d;
      end
   end

   assign bus.o_ready = (state_q == StIdle);
   assign bus.o_valid = (state_q == StDone);
   assign bus.out     = out_q;
endmodule

// File: doc/comparator_iter.md
# comparator_iter

Multi-cycle, parametrised comparator that compares two N-bit operands CHUNK bits per cycle, MSB chunk first. It supports four modes: equal, not-equal, signed less-than and unsigned less-than. It sits beside the combinational comparators in the datapath library and is used where a single-cycle N-bit compare would limit timing. Operands enter and results leave through valid/ready handshakes.

## Interface
- N, 32, operand width in bits; N % CHUNK == 0 required
- CHUNK, 8, bits compared per cycle; 1 ≤ CHUNK ≤ N; K = N/CHUNK chunks
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  N  first operand, sampled on accept
- b  input  N  second operand, sampled on accept
- mode  input  2  00 EQ, 01 NE, 10 LT (signed), 11 LTU (unsigned), sampled on accept
- i_valid  input  1  request valid
- o_ready  output  1  block can accept a request; high only in IDLE
- o_valid  output  1  result valid; high only in DONE
- i_ready  input  1  consumer accepts result
- out  output  1  comparison result, meaningful when o_valid

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - o_ready=1.
  - When i_valid is high, the block accepts the request: it latches a, b and mode, clears the decided and lt flags, sets chunk index idx=K-1 and moves to RUN.
- **RUN**, one chunk per cycle:
  - Compare ca = a_q[idx*CHUNK +: CHUNK] against cb = b_q[idx*CHUNK +: CHUNK].
  - In LT mode, bit N-1 of both latched operands is inverted at latch time. An unsigned compare then gives the signed result.
  - If decided=0 and ca≠cb: set decided=1 and lt=(ca<cb), unsigned.
  - If idx==0: go to DONE. Otherwise decrement idx.
  - i_valid is ignored while in RUN.
- **DONE**
  - o_valid=1.
  - out is: EQ → ~decided; NE → decided; LT/LTU → lt.
  - out and o_valid stay stable until i_valid... specifically until i_ready is high, then the block returns to IDLE.
  - i_valid is ignored while in DONE.
- out is registered. It holds its last value outside DONE.
- Reset at any point, including mid-RUN or in DONE:
  - Next state IDLE, o_valid=0, out=0, flags cleared.
  - The in-flight request is discarded. No result is produced for it.

## Timing
- Reset values: o_ready=1, o_valid=0, out=0, state IDLE.
- Accept on edge t. RUN handles one chunk per edge.
- Without early exit, o_valid rises exactly K cycles after the accept edge, for every request.
- After result handshake on edge u, o_ready=1 from u+1. The next accept can happen at u+1 at the earliest.
- Throughput is at most one result per K+2 cycles, with no backpressure.
- K=1 is legal: a single RUN cycle, o_valid at t+1.

## Configuration
- COMPARATOR_ITER_EARLY_EXIT_EN
  - **Defined:** in RUN, once the first differing chunk sets decided, the block goes straight to DONE on that edge. If the first difference is at chunk j (counted from the MSB chunk, starting at 1), o_valid rises j cycles after accept. Equal operands still take K cycles.
  - **Undefined:** always K RUN cycles. Latency is fixed and independent of the data.
  - out is identical in both configurations.

## Test plan
- N=32, CHUNK=8, a=b=0xDEADBEEF, mode EQ → out=1; o_valid 4 cycles after accept in both configurations; NE on the same operands → out=0.
- a=0xFFFFFFFF, b=0x00000001:
  - LT → out=1, LTU → out=0.
  - With early exit, o_valid 1 cycle after accept; without, 4 cycles.
- a=0x12345678, b=0x12345679:
  - NE → out=1, LTU → out=1, with o_valid after 4 cycles in both configurations.
  - a=b+1 under LTU → out=0.
- Backpressure: hold i_ready=0 for 5 cycles in DONE, pulsing i_valid with new operands → o_valid and out stay stable, o_ready=0, and the new request is not accepted. Raise i_ready → o_ready=1 next cycle.
- Assert rst for one cycle on the 2nd RUN cycle → next cycle IDLE, o_valid=0, out=0, o_ready=1. A following EQ request with a=b=0 → out=1 after 4 cycles.
- N=8, CHUNK=1, a=0x80, b=0x7F, LT → out=1; o_valid after 1 cycle with early exit, 8 cycles without.
